// File: rtl/exec_wb_stage_pkg.sv
// exec_wb_stage_pkg: shared widths, opcode constants and immediate sign-extension
package exec_wb_stage_pkg;
    localparam int DATA_W = 16;
    localparam int IMM_W  = 6;
    localparam int AW     = 3;
    localparam int NREGS  = 8;
    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_OR      = 4'h3;
    localparam logic [3:0] OP_XOR     = 4'h4;
    localparam logic [3:0] OP_SLL     = 4'h5;
    localparam logic [3:0] OP_SRL     = 4'h6;
    localparam logic [3:0] OP_SLT     = 4'h7;
    localparam logic [3:0] OP_MOV     = 4'h8;
    localparam logic [3:0] OP_NOT     = 4'h9;
    localparam logic [3:0] OP_NOP_MIN = 4'hA;
    function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction
endpackage

// File: rtl/regfile_8x16.sv
// regfile_8x16: 8x16 register file, R0 hardwired to zero, sync write, async reads
module regfile_8x16
    import exec_wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    input  logic [AW-1:0]     raddr_d,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_d
);
    logic [DATA_W-1:0] regs [NREGS];

    assign rdata_a = raddr_a == '0 ? '0 : regs[raddr_a];
    assign rdata_b = raddr_b == '0 ? '0 : regs[raddr_b];
    assign rdata_d = raddr_d == '0 ? '0 : regs[raddr_d];

    // clear everything on reset; writes to R0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/exec_wb_stage.sv
// exec_wb_stage: operand read with forwarding, ALU, flags and EX->WB register
module exec_wb_stage
    import exec_wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        opcode,
    input  logic [AW-1:0]     rreg1,
    input  logic [AW-1:0]     rreg2,
    input  logic [AW-1:0]     wreg,
    input  logic [IMM_W-1:0]  imm,
    input  logic              src2_sel,
    input  logic              alu_out_sel,
    input  logic              reg_write,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              wb_en,
    output logic [AW-1:0]     wb_reg,
    output logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] rf_a, rf_b, a, b_reg, b, imm_x, alu, res;
    logic [DATA_W:0]   sum;
    logic              issue;

    regfile_8x16 u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_reg),
        .wdata   (wb_data),
        .raddr_a (rreg1),
        .raddr_b (rreg2),
        .raddr_d (dbg_addr),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .rdata_d (dbg_data)
    );

    assign imm_x = sext(imm);
    assign a     = (wb_en && rreg1 != '0 && wb_reg == rreg1) ? wb_data : rf_a;
    assign b_reg = (wb_en && rreg2 != '0 && wb_reg == rreg2) ? wb_data : rf_b;
    assign b     = src2_sel ? imm_x : b_reg;
    assign sum   = {1'b0, a} + {1'b0, b};
    assign res   = alu_out_sel ? imm_x : alu;
    assign issue = in_valid && opcode < OP_NOP_MIN;

    // ALU result for the opcode; NOP range yields zero but is never used
    always_comb begin
        alu = '0;
        case (opcode)
            OP_ADD:  alu = sum[DATA_W-1:0];
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SLL:  alu = a << b[3:0];
            OP_SRL:  alu = a >> b[3:0];
            OP_SLT:  alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_MOV:  alu = b;
            OP_NOT:  alu = ~a;
            default: alu = '0;
        endcase
    end

    // WB register and flags; only real issues update them, R0 targets never write back
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en      <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            wb_en <= issue && reg_write && wreg != '0;
            if (issue) begin
                wb_reg    <= wreg;
                wb_data   <= res;
                zero_flag <= alu == '0;
                if (opcode == OP_ADD) carry_flag <= sum[DATA_W];
                else if (opcode == OP_SUB) carry_flag <= a < b;
            end
        end
    end
endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: vector table, directed corner sequences and random run against a reference model
module tb_exec_wb_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, src2_sel, alu_out_sel, reg_write;
    logic [3:0]  opcode;
    logic [2:0]  rreg1, rreg2, wreg, wb_reg, dbg_addr;
    logic [5:0]  imm;
    logic        zero_flag, carry_flag, wb_en;
    logic [15:0] wb_data, dbg_data;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    exec_wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .rreg1(rreg1), .rreg2(rreg2), .wreg(wreg), .imm(imm),
        .src2_sel(src2_sel), .alu_out_sel(alu_out_sel), .reg_write(reg_write),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // arch: register values seen by the next instruction; rf: what the register file holds
    longint arch [8];
    longint rf [8];
    bit     m_en, m_z, m_c;
    longint m_reg, m_data;

    typedef struct {
        logic [3:0] op;
        logic [2:0] r1, r2, wr;
        logic [5:0] im;
        logic       s2, aos, rw;
        logic       en;
        logic [15:0] d;
        logic       z, c;
    } vec_t;
    vec_t tv [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint msext(input logic [5:0] v);
        return v >= 32 ? longint'(v) + 65536 - 64 : longint'(v);
    endfunction

    function automatic longint as_signed(input longint v);
        return v >= 32768 ? v - 65536 : v;
    endfunction

    task automatic model_edge();
        longint a, b, s, alu;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin arch[i] = 0; rf[i] = 0; end
            m_en = 0; m_reg = 0; m_data = 0; m_z = 0; m_c = 0;
            return;
        end
        if (m_en) rf[m_reg] = m_data;
        m_en = 0;
        if (!in_valid || opcode > 9) return;
        s = msext(imm);
        a = arch[rreg1];
        b = src2_sel ? s : arch[rreg2];
        alu = 0;
        case (opcode)
            0: begin alu = (a + b) % 65536; m_c = (a + b) > 65535; end
            1: begin alu = (a - b + 65536) % 65536; m_c = a < b; end
            2: alu = a & b;
            3: alu = a | b;
            4: alu = a ^ b;
            5: alu = (a * (longint'(1) << (b % 16))) % 65536;
            6: alu = a / (longint'(1) << (b % 16));
            7: alu = as_signed(a) < as_signed(b) ? 1 : 0;
            8: alu = b;
            default: alu = 65535 - a;
        endcase
        m_z = alu == 0;
        m_en = reg_write && wreg != 0;
        m_reg = wreg;
        m_data = alu_out_sel ? s : alu;
        if (m_en) arch[wreg] = m_data;
    endtask

    task automatic check_model();
        chk("model_wb_en", wb_en, m_en);
        if (m_en) begin
            chk("model_wb_reg", wb_reg, m_reg);
            chk("model_wb_data", wb_data, m_data);
        end
        chk("model_zero", zero_flag, m_z);
        chk("model_carry", carry_flag, m_c);
        chk("model_dbg", dbg_data, rf[dbg_addr]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] r1, r2, wr, input logic [5:0] im,
                         input logic s2, aos, rw);
        in_valid = 1'b1; opcode = op; rreg1 = r1; rreg2 = r2; wreg = wr; imm = im;
        src2_sel = s2; alu_out_sel = aos; reg_write = rw;
    endtask

    task automatic idle();
        in_valid = 1'b0; opcode = 4'h0; reg_write = 1'b0;
    endtask

    initial begin
        tv[0]  = '{4'h8, 3'd0, 3'd0, 3'd1, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tv[1]  = '{4'h0, 3'd1, 3'd0, 3'd2, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
        tv[2]  = '{4'h1, 3'd0, 3'd1, 3'd3, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
        tv[3]  = '{4'h8, 3'd0, 3'd0, 3'd1, 6'h05, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1};
        tv[4]  = '{4'h8, 3'd0, 3'd0, 3'd2, 6'h07, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b1};
        tv[5]  = '{4'h0, 3'd1, 3'd2, 3'd3, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0};
        tv[6]  = '{4'h1, 3'd3, 3'd1, 3'd4, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0};
        tv[7]  = '{4'h8, 3'd0, 3'd0, 3'd0, 6'h05, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[8]  = '{4'hC, 3'd1, 3'd2, 3'd3, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[9]  = '{4'h8, 3'd0, 3'd0, 3'd6, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
        tv[10] = '{4'h5, 3'd6, 3'd0, 3'd7, 6'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b0};
        tv[11] = '{4'h3, 3'd7, 3'd6, 3'd1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0};
        tv[12] = '{4'h5, 3'd1, 3'd0, 3'd2, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0};
        tv[13] = '{4'h6, 3'd1, 3'd0, 3'd3, 6'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
        tv[14] = '{4'h7, 3'd1, 3'd0, 3'd4, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
        tv[15] = '{4'h4, 3'd1, 3'd1, 3'd5, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[16] = '{4'h9, 3'd0, 3'd0, 3'd5, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tv[17] = '{4'h2, 3'd1, 3'd0, 3'd6, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0};
        tv[18] = '{4'h4, 3'd1, 3'd1, 3'd7, 6'h05, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0};

        rst = 1'b1; dbg_addr = 3'd0; imm = 6'h0; rreg1 = 3'd0; rreg2 = 3'd0; wreg = 3'd0;
        src2_sel = 1'b0; alu_out_sel = 1'b0; idle();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_wb_en", wb_en, 1'b0);
        chk("reset_wb_reg", wb_reg, 3'd0);
        chk("reset_wb_data", wb_data, 16'h0);
        chk("reset_zero", zero_flag, 1'b0);
        chk("reset_carry", carry_flag, 1'b0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("reset_dbg_r%0d", r), dbg_data, 16'h0);
        end

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].op, tv[i].r1, tv[i].r2, tv[i].wr, tv[i].im, tv[i].s2, tv[i].aos, tv[i].rw);
            dbg_addr = 3'(i % 8);
            tick();
            chk($sformatf("tv%0d_wb_en", i), wb_en, tv[i].en);
            if (tv[i].en) chk($sformatf("tv%0d_wb_data", i), wb_data, tv[i].d);
            chk($sformatf("tv%0d_zero", i), zero_flag, tv[i].z);
            chk($sformatf("tv%0d_carry", i), carry_flag, tv[i].c);
        end
        idle();
        tick();
        tick();
        begin
            logic [15:0] fin [8];
            fin = '{16'h0000, 16'h8001, 16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'h8001, 16'h0005};
            for (int r = 0; r < 8; r++) begin
                dbg_addr = 3'(r);
                #1;
                chk($sformatf("final_dbg_r%0d", r), dbg_data, fin[r]);
            end
        end

        drive(4'h8, 3'd0, 3'd0, 3'd1, 6'h3F, 1'b1, 1'b0, 1'b1);
        tick();
        drive(4'h0, 3'd1, 3'd0, 3'd5, 6'h01, 1'b1, 1'b0, 1'b1);
        tick();
        chk("midrst_pre_zero", zero_flag, 1'b1);
        chk("midrst_pre_carry", carry_flag, 1'b1);
        chk("midrst_pre_wb_en", wb_en, 1'b1);
        rst = 1'b1;
        drive(4'h0, 3'd1, 3'd1, 3'd6, 6'h00, 1'b0, 1'b0, 1'b1);
        dbg_addr = 3'd5;
        tick();
        rst = 1'b0;
        idle();
        chk("midrst_wb_en", wb_en, 1'b0);
        chk("midrst_zero", zero_flag, 1'b0);
        chk("midrst_carry", carry_flag, 1'b0);
        chk("midrst_r5", dbg_data, 16'h0);
        tick();
        chk("midrst_r5_later", dbg_data, 16'h0);
        dbg_addr = 3'd1;
        #1;
        chk("midrst_r1", dbg_data, 16'h0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom % 60) == 0;
            in_valid = ($urandom % 8) != 0;
            opcode = 4'($urandom);
            rreg1 = 3'($urandom);
            rreg2 = 3'($urandom);
            wreg = 3'($urandom);
            imm = 6'($urandom);
            src2_sel = 1'($urandom);
            alu_out_sel = ($urandom % 4) == 0;
            reg_write = ($urandom % 6) != 0;
            dbg_addr = 3'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Datapath stage directly downstream of Control_logic_01 in the 16-bit custom processor.
- Consumes its decoded control word: OPCODE, register selects, immediate, Source2_select, ALU_out_Select and RegWrite_Flag.
- Holds the 8x16 register file and the ALU, plus one EX->WB pipeline register with forwarding.
- Returns zero/carry flags to the control logic for branch decisions.

Parameters:
- DATA_W, 16, datapath and register width.
- NREGS, 8, register count; address width is 3.
- IMM_W, 6, immediate width; sign-extended to DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  control word on the inputs is a real instruction this cycle.
- opcode  in  4  ALU operation.
- rreg1  in  3  source A register.
- rreg2  in  3  source B register.
- wreg  in  3  destination register.
- imm  in  6  immediate field.
- src2_sel  in  1  0 = B from rreg2, 1 = B is sign-extended imm.
- alu_out_sel  in  1  0 = write ALU result, 1 = write sign-extended imm directly.
- reg_write  in  1  destination write enable.
- zero_flag  out  1  registered; result == 0 of the last flag-updating op.
- carry_flag  out  1  registered; ADD carry-out / SUB borrow.
- wb_en  out  1  registered; a writeback is pending this cycle.
- wb_reg  out  3  registered destination of the pending writeback.
- wb_data  out  16  registered data of the pending writeback.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational regfile read at dbg_addr; no forwarding.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All 8 registers are cleared to 0.
  - wb_en, wb_reg, wb_data, zero_flag and carry_flag are cleared to 0.
  - A pending writeback is discarded and never reaches the regfile.
  - rst dominates in_valid.
- R0 is hardwired to 0:
  - Reads of R0 return 0.
  - Writes to R0 are dropped, and wb_en stays 0 for them.
- Operand read (combinational, in the issue cycle):
  - A = reg[rreg1]; B = src2_sel ? sext(imm) : reg[rreg2].
  - Forwarding: if wb_en=1 and wb_reg equals a source register (non-zero), that operand takes wb_data.
- ALU opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SLL by B[3:0], 6 SRL by B[3:0] (logical), 7 SLT (signed, result 1/0).
  - 8 MOV (result = B), 9 NOT (result = ~A).
  - A-F are NOP: no writeback and no flag update, regardless of reg_write.
  - All arithmetic is modulo 2^16.
- Result select: res = alu_out_sel ? sext(imm) : alu_result.
- Issue edge (in_valid=1, opcode<=9):
  - wb_en <= reg_write && wreg!=0; wb_reg <= wreg; wb_data <= res.
  - zero_flag <= (alu_result==0).
  - carry_flag <= carry-out for ADD, borrow (A<B unsigned) for SUB; unchanged for other opcodes.
- in_valid=0 or NOP at an edge: wb_en <= 0; flags hold.
- Writeback: at the edge following issue, if wb_en=1 then reg[wb_reg] <= wb_data.
  - Net latency: result is in the regfile 2 edges after issue and visible on dbg_data from then.
  - Dependent instructions can issue back-to-back with no stall, via forwarding.
- Simultaneous writeback and new issue: both occur at the same edge. The new issue's operands already see the old result through forwarding.
- Pipeline: fixed one instruction per cycle; no backpressure and no stall input.

Decomposition:
- Shared package/include file holds:
  - Opcode constants: OP_ADD..OP_NOT, and OP_NOP_MIN=4'hA.
  - DATA_W, IMM_W and register address width.
- Natural sub-module: regfile_8x16, with two async read ports, one sync write port, R0 hardwired zero and synchronous clear on rst.
- ALU, forwarding muxes and the WB register stay in exec_wb_stage.

Test Plan:
- Reset then MOV imm: rst 2 cycles, then issue MOV R1, imm=6'h3F, src2_sel=1, reg_write=1 -> wb_data=16'hFFFF; 2 edges later dbg_data@R1=16'hFFFF, zero_flag=0.
- Back-to-back forwarding: R1=5, R2=7 loaded; ADD R3=R1+R2, then immediately SUB R4=R3-R1 -> R3=12, R4=7, with no bubble.
- Carry/borrow: R1=16'hFFFF, ADD R2=R1+imm 1 -> R2=0, zero_flag=1, carry_flag=1. Then SUB R3=R0-R1 -> R3=1, carry_flag=1, zero_flag=0.
- R0 and NOP protection:
  - MOV R0, imm 5 -> wb_en=0, R0 reads 0.
  - Opcode 4'hC with reg_write=1 -> no register changes, flags unchanged.
- Shifts/SLT: R1=16'h8001; SLL by 1 -> 16'h0002; SRL by 15 -> 1; SLT R1<R0 -> 1.
- Reset mid-op: issue ADD R5 in cycle N, assert rst at edge N+1 -> R5 stays 0, wb_en=0 and all flags 0 afterwards.
